alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder together with the two 32-bit operands from the ID/EX register. AND, OR, ADD, SUB and SLT complete in one cycle. MUL runs on an iterative 32-cycle shift-add multiplier, during which the unit deasserts `ready_o` so the hazard unit stalls the front end. Results are registered and presented to EX/MEM with a one-cycle `valid_o` pulse.

---
 rtl/alu_pkg.sv | 19 +
 rtl/shift_add_mul.sv | 62 ++++++
 rtl/alu_exec_unit.sv | 133 +++++++++++++
 tb/tb_alu_exec_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute-stage ALU:
// control codes, FSM state encoding and the default datapath width.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } alu_state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per clock, exactly WIDTH
// iterations, low WIDTH bits of the product.
module shift_add_mul #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] mcand_i,
   input  logic [WIDTH-1:0] mplier_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             busy_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] acc_next_s;

   // Accumulator value after the current iteration's conditional add
   always_comb begin
      acc_next_s = acc_r;
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
   end

   // The final product is taken from the adder so it is ready on the last edge
   assign done_o    = busy_r && (count_r == LAST);
   assign product_o = acc_next_s;

   // Operand latch on start, then one shift-add step per edge while busy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_r   <= 1'b0;
         count_r  <= {CW{1'b0}};
         mcand_r  <= {WIDTH{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
      end else if (start_i) begin
         busy_r   <= 1'b1;
         count_r  <= {CW{1'b0}};
         mcand_r  <= mcand_i;
         mplier_r <= mplier_i;
         acc_r    <= {WIDTH{1'b0}};
      end else if (busy_r) begin
         acc_r    <= acc_next_s;
         mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
         count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
         busy_r   <= (count_r != LAST);
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops plus an iterative
// multiply that stalls the front end through ready_o.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [2:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   alu_state_e       state_r;
   alu_state_e       state_next_s;
   logic             accept_s;
   logic             is_mul_s;
   logic             mul_start_s;
   logic             mul_done_s;
   logic [WIDTH-1:0] mul_result_s;
   logic [WIDTH-1:0] alu_result_s;
   logic [WIDTH-1:0] data_r;
   logic             zero_r;
   logic             valid_r;

   assign accept_s    = valid_i && ready_o;
   assign is_mul_s    = (ALUCtrl_i == ALU_MUL);
   assign mul_start_s = accept_s && is_mul_s;

   shift_add_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (mul_start_s),
      .mcand_i   (data1_i),
      .mplier_i  (data2_i),
      .done_o    (mul_done_s),
      .product_o (mul_result_s)
   );

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (mul_start_s) begin
               state_next_s = MUL_RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         MUL_RUN: begin
            if (mul_done_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = MUL_RUN;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // FSM output: reset also masks ready so nothing is accepted while held
   always_comb begin
      ready_o = 1'b0;
      if ((state_r == IDLE) && !rst_i) begin
         ready_o = 1'b1;
      end else begin
         ready_o = 1'b0;
      end
   end

   // Single-cycle datapath; undefined codes yield zero
   always_comb begin
      alu_result_s = {WIDTH{1'b0}};
      case (ALUCtrl_i)
         ALU_AND: alu_result_s = data1_i & data2_i;
         ALU_OR:  alu_result_s = data1_i | data2_i;
         ALU_ADD: alu_result_s = data1_i + data2_i;
         ALU_SUB: alu_result_s = data1_i - data2_i;
         ALU_SLT: begin
            if ($signed(data1_i) < $signed(data2_i)) begin
               alu_result_s = ONE;
            end else begin
               alu_result_s = {WIDTH{1'b0}};
            end
         end
         default: alu_result_s = {WIDTH{1'b0}};
      endcase
   end

   // Result registers: loaded on a single-cycle accept or on multiply completion
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_r  <= {WIDTH{1'b0}};
         zero_r  <= 1'b0;
         valid_r <= 1'b0;
      end else if (accept_s && !is_mul_s) begin
         data_r  <= alu_result_s;
         zero_r  <= (alu_result_s == {WIDTH{1'b0}});
         valid_r <= 1'b1;
      end else if (mul_done_s) begin
         data_r  <= mul_result_s;
         zero_r  <= (mul_result_s == {WIDTH{1'b0}});
         valid_r <= 1'b1;
      end else begin
         valid_r <= 1'b0;
      end
   end

   assign data_o  = data_r;
   assign zero_o  = zero_r;
   assign valid_o = valid_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases followed by random
// operations checked against a plain-arithmetic reference model.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [2:0]  ctrl = 3'b000;
   logic [31:0] d1 = 32'd0;
   logic [31:0] d2 = 32'd0;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] data_o;
   logic        zero_o;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .valid_i   (valid_i),
      .ALUCtrl_i (ctrl),
      .data1_i   (d1),
      .data2_i   (d2),
      .ready_o   (ready_o),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .zero_o    (zero_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      case (c)
         3'b000: return a & b;
         3'b001: return a | b;
         3'b010: return a + b;
         3'b110: return a - b;
         3'b011: begin
            p = {32'd0, a} * {32'd0, b};
            return p[31:0];
         end
         3'b111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      exp = ref_alu(c, a, b);
      @(negedge clk);
      check({tag, " ready"}, {63'd0, ready_o}, 64'd1);
      valid_i = 1'b1; ctrl = c; d1 = a; d2 = b;
      @(negedge clk);
      valid_i = 1'b0;
      check({tag, " valid"}, {63'd0, valid_o}, 64'd1);
      check({tag, " data"}, {32'd0, data_o}, {32'd0, exp});
      check({tag, " zero"}, {63'd0, zero_o}, {63'd0, (exp == 32'd0)});
      @(negedge clk);
      check({tag, " pulse"}, {63'd0, valid_o}, 64'd0);
      check({tag, " hold"}, {32'd0, data_o}, {32'd0, exp});
   endtask

   task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic hold_add);
      logic [31:0] exp;
      int n;
      logic saw_ready;
      exp = ref_alu(3'b011, a, b);
      @(negedge clk);
      check({tag, " ready"}, {63'd0, ready_o}, 64'd1);
      valid_i = 1'b1; ctrl = 3'b011; d1 = a; d2 = b;
      @(negedge clk);
      // operands change and (optionally) an ADD request is held during the run
      valid_i = hold_add; ctrl = 3'b010; d1 = 32'd1; d2 = 32'd1;
      n = 1;
      saw_ready = 1'b0;
      while (!valid_o && n < 40) begin
         if (ready_o) saw_ready = 1'b1;
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'd33);
      check({tag, " stall"}, {63'd0, saw_ready}, 64'd0);
      check({tag, " ready back"}, {63'd0, ready_o}, 64'd1);
      check({tag, " data"}, {32'd0, data_o}, {32'd0, exp});
      check({tag, " zero"}, {63'd0, zero_o}, {63'd0, (exp == 32'd0)});
      @(negedge clk);
      valid_i = 1'b0;
      if (hold_add) begin
         check({tag, " held add valid"}, {63'd0, valid_o}, 64'd1);
         check({tag, " held add data"}, {32'd0, data_o}, 64'd2);
      end else begin
         check({tag, " pulse"}, {63'd0, valid_o}, 64'd0);
      end
   endtask

   initial begin
      logic [2:0] codes [8];
      logic [2:0] c;
      logic [31:0] a;
      logic [31:0] b;
      int vcount;
      codes = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101, 3'b011};

      // reset state
      repeat (3) @(negedge clk);
      check("rst data", {32'd0, data_o}, 64'd0);
      check("rst zero", {63'd0, zero_o}, 64'd0);
      check("rst valid", {63'd0, valid_o}, 64'd0);
      check("rst ready", {63'd0, ready_o}, 64'd0);
      rst = 1'b0;
      #1;
      check("post rst ready", {63'd0, ready_o}, 64'd1);

      do_op("add 7+5", 3'b010, 32'd7, 32'd5);
      do_op("sub 5-5", 3'b110, 32'd5, 32'd5);
      do_op("sub 0-1", 3'b110, 32'd0, 32'd1);
      do_op("slt -1<1", 3'b111, 32'hFFFF_FFFF, 32'd1);
      do_op("slt 1<-1", 3'b111, 32'd1, 32'hFFFF_FFFF);
      do_op("undef 101", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0);

      // back-to-back AND then OR
      @(negedge clk);
      valid_i = 1'b1; ctrl = 3'b000; d1 = 32'h0000_F0F0; d2 = 32'h0000_FF00;
      @(negedge clk);
      ctrl = 3'b001; d1 = 32'h0000_F0F0; d2 = 32'h0000_0F0F;
      check("b2b and valid", {63'd0, valid_o}, 64'd1);
      check("b2b and data", {32'd0, data_o}, 64'h0000_F000);
      @(negedge clk);
      valid_i = 1'b0;
      check("b2b or valid", {63'd0, valid_o}, 64'd1);
      check("b2b or data", {32'd0, data_o}, 64'h0000_FFFF);
      @(negedge clk);
      check("b2b pulse end", {63'd0, valid_o}, 64'd0);

      do_mul("mul 1234x5678", 32'd1234, 32'd5678, 1'b0);
      check("mul 1234x5678 const", {32'd0, data_o}, 64'd7006652);
      do_mul("mul ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      do_mul("mul zero", 32'd0, 32'h1234_5678, 1'b0);
      do_mul("mul held add", 32'd3, 32'd7, 1'b1);

      // reset in the middle of a multiply
      do_op("pre-reset add", 32'd0 == 32'd0 ? 3'b010 : 3'b010, 32'd40, 32'd2);
      @(negedge clk);
      valid_i = 1'b1; ctrl = 3'b011; d1 = 32'd3; d2 = 32'd5;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst data", {32'd0, data_o}, 64'd0);
      check("midrst zero", {63'd0, zero_o}, 64'd0);
      check("midrst valid", {63'd0, valid_o}, 64'd0);
      check("midrst ready", {63'd0, ready_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst ready after", {63'd0, ready_o}, 64'd1);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (valid_o) vcount++;
      end
      check("midrst no valid", 64'(vcount), 64'd0);
      check("midrst data after", {32'd0, data_o}, 64'd0);

      // random operations against the reference model
      for (int i = 0; i < 30; i++) begin
         c = codes[$urandom_range(0, 7)];
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? a : $urandom;
         if (c == 3'b011) begin
            do_mul("rnd mul", a, b, 1'b0);
         end else begin
            do_op("rnd op", c, a, b);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
